// File: rtl/dtm_dmi_ctrl_if.sv
// DM request/response channel between the DTM DMI controller (master) and the
// debug module (slave).
interface dtm_dmi_ctrl_if #(
  parameter int unsigned ABITS = 7
) ();
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [1:0]       rsp_op;

  modport master (
    output req_valid, req_addr, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/dtm_dmi_ctrl.sv
// JTAG DTM side of the DMI: turns UPDATE_DR/CAPTURE_DR pulses into single
// outstanding DM transactions and tracks the sticky dmistat error.
module dtm_dmi_ctrl #(
  parameter int unsigned ABITS = 7
) (
  input  logic              tclk,
  input  logic              trst,
  input  logic              dmi_update,
  input  logic              dmi_capture,
  input  logic [ABITS+33:0] dmi_wdata,
  output logic [ABITS+33:0] dmi_rdata,
  input  logic              dtmcs_update,
  input  logic [1:0]        dtmcs_wdata,
  output logic [1:0]        dmistat,
  dtm_dmi_ctrl_if.master    dm
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sticky;
  logic [1:0]       w_sticky_nxt;
  logic [ABITS-1:0] r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_op;
  logic [31:0]      r_result;
  logic             r_rsp_ready;
  logic             w_latch;
  logic             w_res_load;
  logic [31:0]      w_res_val;
  logic             w_dtmcs_clr;
  logic             w_upd;
  logic             w_op_acc;
  logic [1:0]       w_cap_op;

  always_ff @(posedge tclk) begin
    if (!trst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sticky_nxt = r_sticky;
    w_latch      = 1'b0;
    w_res_load   = 1'b0;
    w_res_val    = r_result;
    w_dtmcs_clr  = dtmcs_update && (dtmcs_wdata != 2'b00);
    w_upd        = dmi_update && !w_dtmcs_clr;
    w_op_acc     = (dmi_wdata[1:0] == 2'd1) || (dmi_wdata[1:0] == 2'd2);

    case (r_state)
      ST_IDLE: begin
        if (w_upd && (r_sticky == 2'd0) && w_op_acc) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dm.req_ready) w_state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (dm.rsp_valid && r_rsp_ready) begin
          w_state_nxt = ST_IDLE;
          if (dm.rsp_op == 2'd0) begin
            w_res_load = 1'b1;
            w_res_val  = (r_op == 2'd1) ? dm.rsp_data : r_data;
          end else if (dm.rsp_op[1] && (r_sticky == 2'd0)) begin
            w_sticky_nxt = 2'd2;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Busy is only recorded if no failure was recorded this same cycle.
    if ((r_state != ST_IDLE) && (w_sticky_nxt == 2'd0) && (w_upd || dmi_capture))
      w_sticky_nxt = 2'd3;

    if (w_dtmcs_clr) begin
      w_sticky_nxt = 2'd0;
      if (dtmcs_wdata[1]) w_state_nxt = ST_IDLE;
    end

    if (r_sticky != 2'd0)        w_cap_op = r_sticky;
    else if (r_state != ST_IDLE) w_cap_op = 2'd3;
    else                         w_cap_op = 2'd0;
  end

  always_ff @(posedge tclk) begin
    if (!trst) begin
      r_sticky    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_rsp_ready <= 1'b0;
      dmi_rdata   <= '0;
    end else begin
      r_sticky    <= w_sticky_nxt;
      r_rsp_ready <= 1'b1;
      if (w_latch) begin
        r_addr <= dmi_wdata[ABITS+33:34];
        r_data <= dmi_wdata[33:2];
        r_op   <= dmi_wdata[1:0];
      end
      if (w_res_load) r_result <= w_res_val;
      if (dmi_capture) dmi_rdata <= {r_addr, r_result, w_cap_op};
    end
  end

  assign dm.req_valid = (r_state == ST_REQ);
  assign dm.req_addr  = r_addr;
  assign dm.req_data  = r_data;
  assign dm.req_op    = r_op;
  assign dm.rsp_ready = r_rsp_ready;
  assign dmistat      = r_sticky;

endmodule

// File: doc/dtm_dmi_ctrl.md
DTM_DMI_CTRL -- requirements
Module: dtm_dmi_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width; DMI register width W = ABITS+34.
REQ-002 SHALL have tclk  input  1  single clock, all logic on posedge tclk.
REQ-003 SHALL have trst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have dmi_update  input  1  one-cycle pulse, TAP in UPDATE_DR with DMI instruction selected.
REQ-005 SHALL have dmi_capture  input  1  one-cycle pulse, TAP in CAPTURE_DR with DMI instruction selected.
REQ-006 SHALL have dmi_wdata  input  W  shifted-in DMI value {addr[W-1:34], data[33:2], op[1:0]}.
REQ-007 SHALL have dmi_rdata  output  W  capture value {addr, data, op}, registered.
REQ-008 SHALL have dtmcs_update  input  1  one-cycle pulse, UPDATE_DR with DTMCS selected.
REQ-009 SHALL have dtmcs_wdata  input  2  {dmihardreset, dmireset} (dtmcs bits 17:16).
REQ-010 SHALL have dmistat  output  2  sticky DMI status.
REQ-011 SHALL have req_valid, req_ready, req_addr[ABITS], req_data[32], req_op[2]  out/in/out/out/out  DM request channel, op 1=read, 2=write.
REQ-012 SHALL have rsp_valid, rsp_ready, rsp_data[32], rsp_op[2]  in/out/in/in  DM response channel, op 0=ok, 2/3=failed.

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT_RSP; one transaction outstanding at most.
REQ-014 IDLE: dmi_update with op 1 or 2, sticky==0, no dtmcs_update in same cycle -> latch addr/data/op, go REQ; req_valid=1 next cycle.
REQ-015 dmi_update with op 0 or 3 SHALL perform no DM access and no state change.
REQ-016 dmi_update while sticky!=0 SHALL be ignored (no access, latched fields unchanged).
REQ-017 dmi_update while state!=IDLE SHALL drop the new request and set sticky=3 if sticky==0.
REQ-018 REQ: req_valid, req_addr, req_data, req_op SHALL hold stable until req_valid&&req_ready; then WAIT_RSP next cycle, req_valid=0.
REQ-019 rsp_ready SHALL be 1 in every state except reset; responses arriving outside WAIT_RSP SHALL be discarded.
REQ-020 WAIT_RSP, rsp_valid: rsp_op==0 -> result data = rsp_data for read, latched write data for write; rsp_op 2 or 3 -> result data unchanged, sticky=2 if sticky==0; go IDLE.
REQ-021 Minimum latency: dmi_update at cycle N -> req_valid at N+1; ready at N+1 and rsp_valid at N+2 -> IDLE at N+3.
REQ-022 dmi_capture SHALL load dmi_rdata next cycle = {latched addr, result data, op}, op = sticky if sticky!=0, else 3 if state!=IDLE, else 0.
REQ-023 dmi_capture while state!=IDLE and sticky==0 SHALL also set sticky=3.
REQ-024 dtmcs_update with dmireset=1 SHALL clear sticky to 0; no effect on FSM.
REQ-025 dtmcs_update with dmihardreset=1 SHALL clear sticky, force IDLE, deassert req_valid next cycle, abandon outstanding transaction.
REQ-026 dmi_update in same cycle as dtmcs_update with either bit set SHALL be ignored.
REQ-027 Sticky SHALL only go 0->2 or 0->3; first error wins; cleared only by REQ-024/025 or reset.
REQ-028 dmistat SHALL equal sticky register.

Reset
REQ-029 trst low at posedge tclk SHALL give: state IDLE, sticky 0, req_valid 0, req_addr/req_data/req_op 0, rsp_ready 0, dmi_rdata 0, latched addr/result data 0.
REQ-030 Reset mid-transaction SHALL abandon it; req_valid 0 in the cycle after reset sampled.

Verification
REQ-031 Read: dmi_wdata {addr 0x10, op 1}, update; ready=1; rsp_valid, rsp_data 0xDEADBEEF, op 0; capture -> dmi_rdata {0x10, 0xDEADBEEF, 0}, dmistat 0.
REQ-032 Write: {addr 0x04, data 0x12345678, op 2}, update -> req_op 2, req_data 0x12345678 held over 3 cycles ready=0; ok rsp -> capture op 0.
REQ-033 Busy: ready held 0, second dmi_update -> no second request, dmistat 3; capture -> op 3; later dmi_update ignored until dtmcs dmireset -> dmistat 0.
REQ-034 Failure: rsp_op 2 -> dmistat 2; subsequent rsp error or capture during busy keeps 2.
REQ-035 Hardreset in WAIT_RSP -> IDLE next cycle, dmistat 0; late rsp_valid discarded, result data unchanged.
REQ-036 trst low during REQ -> req_valid 0, dmi_rdata 0, dmistat 0 next cycle.
